// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding, stage indices and default widths for the pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic {
        PipeRun    = 1'b0,
        PipeMcWait = 1'b1
    } pipe_state_e;

    localparam int unsigned PipePc    = 0;
    localparam int unsigned PipeIfId  = 1;
    localparam int unsigned PipeIdEx  = 2;
    localparam int unsigned PipeExMem = 3;
    localparam int unsigned PipeMemWb = 4;

    localparam int unsigned PIPE_STAGES_DEF = 5;
    localparam int unsigned PIPE_REG_AW_DEF = 5;
    localparam int unsigned PIPE_XLEN_DEF   = 32;
    localparam int unsigned PIPE_MC_W_DEF   = 6;

endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// Multi-cycle stall countdown: load a value, decrement to zero unless held, flag zero.
module mc_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_W = PIPE_MC_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            hold,
    input  logic [MC_W-1:0] val,
    output logic            zero
);

    logic [MC_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = val;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - MC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-register load-enable/flush for load-use, multi-cycle EX, jumps and hold.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES = PIPE_STAGES_DEF,
    parameter int unsigned REG_AW = PIPE_REG_AW_DEF,
    parameter int unsigned XLEN   = PIPE_XLEN_DEF,
    parameter int unsigned MC_W   = PIPE_MC_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_rs1_read_i,
    input  logic              id_rs2_read_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              ex_load_i,
    input  logic              ex_regs_wen_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_jump_i,
    input  logic [XLEN-1:0]   ex_jump_addr_i,
    input  logic              ex_mc_start_i,
    input  logic [MC_W-1:0]   ex_mc_lat_i,
    input  logic              ext_hold_i,
    output logic [STAGES-1:0] lden_o,
    output logic [STAGES-1:0] flush_o,
    output logic              pc_redirect_o,
    output logic [XLEN-1:0]   pc_redirect_addr_o,
    output logic              state_o,
    output logic [31:0]       ldu_cnt_o,
    output logic [31:0]       mc_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    pipe_state_e state_q, state_d;
    logic        mc_zero;
    logic        mc_entry, mc_busy, mc_stall;
    logic        ldu_hazard, ldu_stall, jump_take;
    logic [4:0]  lden_b, flush_b;

    mc_timer #(.MC_W(MC_W)) u_mc_timer (
        .clk  (clk),
        .rstn (rstn),
        .load (mc_entry && !ext_hold_i),
        .hold (ext_hold_i),
        .val  (ex_mc_lat_i - MC_W'(1)),
        .zero (mc_zero)
    );

    always_comb begin
        mc_entry   = (state_q == PipeRun) && ex_mc_start_i && (ex_mc_lat_i != '0);
        mc_busy    = (state_q == PipeMcWait) && !mc_zero;
        ldu_hazard = ex_load_i && ex_regs_wen_i && (ex_rd_addr_i != '0) &&
                     ((id_rs1_read_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                      (id_rs2_read_i && (id_rs2_addr_i == ex_rd_addr_i)));
        mc_stall   = !ext_hold_i && (mc_entry || mc_busy);
        jump_take  = !ext_hold_i && !(mc_entry || mc_busy) && ex_jump_i;
        ldu_stall  = !ext_hold_i && !(mc_entry || mc_busy) && !ex_jump_i && ldu_hazard;
    end

    always_comb begin
        state_d = state_q;
        if (!ext_hold_i) begin
            if (mc_entry) begin
                state_d = PipeMcWait;
            end else if ((state_q == PipeMcWait) && mc_zero) begin
                state_d = PipeRun;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PipeRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        lden_b  = '1;
        flush_b = '0;
        if (ext_hold_i) begin
            lden_b = '0;
        end else if (mc_stall) begin
            lden_b[PipePc]    = 1'b0;
            lden_b[PipeIfId]  = 1'b0;
            lden_b[PipeIdEx]  = 1'b0;
            flush_b[PipeExMem] = 1'b1;
        end else if (jump_take) begin
            flush_b[PipeIfId] = 1'b1;
            flush_b[PipeIdEx] = 1'b1;
        end else if (ldu_stall) begin
            lden_b[PipePc]   = 1'b0;
            lden_b[PipeIfId] = 1'b0;
            flush_b[PipeIdEx] = 1'b1;
        end
    end

    // Back-end registers beyond mem_wb mirror its control.
    always_comb begin
        lden_o       = {STAGES{lden_b[PipeMemWb]}};
        flush_o      = {STAGES{flush_b[PipeMemWb]}};
        lden_o[4:0]  = lden_b;
        flush_o[4:0] = flush_b;
    end

    assign pc_redirect_o      = jump_take;
    assign pc_redirect_addr_o = ex_jump_addr_i;
    assign state_o            = (state_q == PipeMcWait);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] ldu_cnt_q, ldu_cnt_d;
    logic [31:0] mc_cnt_q, mc_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        ldu_cnt_d   = ldu_cnt_q + (ldu_stall ? 32'd1 : 32'd0);
        mc_cnt_d    = mc_cnt_q + (mc_stall ? 32'd1 : 32'd0);
        flush_cnt_d = flush_cnt_q + (jump_take ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ldu_cnt_q   <= '0;
            mc_cnt_q    <= '0;
            flush_cnt_q <= '0;
        end else begin
            ldu_cnt_q   <= ldu_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ldu_cnt_o   = ldu_cnt_q;
    assign mc_cnt_o    = mc_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign ldu_cnt_o   = '0;
    assign mc_cnt_o    = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (STAGES=7 so the extra back-end bits are exercised).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        id_rs1_read_i, id_rs2_read_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
    logic        ex_load_i, ex_regs_wen_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_mc_start_i;
    logic [5:0]  ex_mc_lat_i;
    logic        ext_hold_i;
    logic [6:0]  lden_o, flush_o;
    logic        pc_redirect_o;
    logic [31:0] pc_redirect_addr_o;
    logic        state_o;
    logic [31:0] ldu_cnt_o, mc_cnt_o, flush_cnt_o;

    typedef struct {
        string       name;
        logic [6:0]  lden;
        logic [6:0]  flush;
        logic        redir;
        logic [31:0] addr;
        logic        st;
        logic [31:0] ldu;
        logic [31:0] mc;
        logic [31:0] fl;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned exp_ldu = 0, exp_mc = 0, exp_fl = 0;

    pipe_ctrl #(.STAGES(7), .REG_AW(5), .XLEN(32), .MC_W(6)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .id_rs1_read_i      (id_rs1_read_i),
        .id_rs2_read_i      (id_rs2_read_i),
        .id_rs1_addr_i      (id_rs1_addr_i),
        .id_rs2_addr_i      (id_rs2_addr_i),
        .ex_load_i          (ex_load_i),
        .ex_regs_wen_i      (ex_regs_wen_i),
        .ex_rd_addr_i       (ex_rd_addr_i),
        .ex_jump_i          (ex_jump_i),
        .ex_jump_addr_i     (ex_jump_addr_i),
        .ex_mc_start_i      (ex_mc_start_i),
        .ex_mc_lat_i        (ex_mc_lat_i),
        .ext_hold_i         (ext_hold_i),
        .lden_o             (lden_o),
        .flush_o            (flush_o),
        .pc_redirect_o      (pc_redirect_o),
        .pc_redirect_addr_o (pc_redirect_addr_o),
        .state_o            (state_o),
        .ldu_cnt_o          (ldu_cnt_o),
        .mc_cnt_o           (mc_cnt_o),
        .flush_cnt_o        (flush_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rstn           = 1'b1;
        id_rs1_read_i  = 1'b0;
        id_rs2_read_i  = 1'b0;
        id_rs1_addr_i  = '0;
        id_rs2_addr_i  = '0;
        ex_load_i      = 1'b0;
        ex_regs_wen_i  = 1'b0;
        ex_rd_addr_i   = '0;
        ex_jump_i      = 1'b0;
        ex_jump_addr_i = '0;
        ex_mc_start_i  = 1'b0;
        ex_mc_lat_i    = '0;
        ext_hold_i     = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Expected 5-stage pattern; bits 5..6 replicate bit 4.
    task automatic expv(input string name, input logic [4:0] l5, input logic [4:0] f5,
                        input logic redir, input logic [31:0] addr, input logic st,
                        input bit ev_l, input bit ev_m, input bit ev_f);
        exp_t e;
        e.name  = name;
        e.lden  = {l5[4], l5[4], l5};
        e.flush = {f5[4], f5[4], f5};
        e.redir = redir;
        e.addr  = addr;
        e.st    = st;
`ifdef PIPE_CTRL_PERF_EN
        e.ldu = exp_ldu;
        e.mc  = exp_mc;
        e.fl  = exp_fl;
`else
        e.ldu = '0;
        e.mc  = '0;
        e.fl  = '0;
`endif
        sb.push_back(e);
        if (ev_l) exp_ldu++;
        if (ev_m) exp_mc++;
        if (ev_f) exp_fl++;
    endtask

    task automatic set_ldu(input logic [4:0] rd, input logic rs2_rd, input logic [4:0] rs2);
        ex_load_i     = 1'b1;
        ex_regs_wen_i = 1'b1;
        ex_rd_addr_i  = rd;
        id_rs2_read_i = rs2_rd;
        id_rs2_addr_i = rs2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_vec++;
                if (lden_o !== e.lden || flush_o !== e.flush || pc_redirect_o !== e.redir ||
                    pc_redirect_addr_o !== e.addr || state_o !== e.st ||
                    ldu_cnt_o !== e.ldu || mc_cnt_o !== e.mc || flush_cnt_o !== e.fl) begin
                    n_bad++;
                    $display("FAIL %s: got lden=%b flush=%b redir=%b addr=%h st=%b cnt=%0d/%0d/%0d, expected lden=%b flush=%b redir=%b addr=%h st=%b cnt=%0d/%0d/%0d",
                             e.name, lden_o, flush_o, pc_redirect_o, pc_redirect_addr_o, state_o,
                             ldu_cnt_o, mc_cnt_o, flush_cnt_o, e.lden, e.flush, e.redir, e.addr,
                             e.st, e.ldu, e.mc, e.fl);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        idle_inputs();
        rstn = 1'b0;

        cyc(); rstn = 1'b0;
        exp_ldu = 0; exp_mc = 0; exp_fl = 0;
        expv("reset", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);

        cyc();
        expv("idle", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);

        // Load-use on rs2 and its one-cycle lifetime
        cyc(); set_ldu(5'd5, 1'b1, 5'd5);
        expv("ldu_rs2", 5'b11100, 5'b00100, 0, 32'h0, 0, 1, 0, 0);
        cyc();
        expv("ldu_after", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);
        cyc(); set_ldu(5'd0, 1'b1, 5'd0);
        expv("ldu_rd0", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);
        cyc(); set_ldu(5'd5, 1'b0, 5'd5);
        expv("ldu_noread", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);
        cyc(); set_ldu(5'd7, 1'b0, 5'd0); id_rs1_read_i = 1'b1; id_rs1_addr_i = 5'd7;
        expv("ldu_rs1", 5'b11100, 5'b00100, 0, 32'h0, 0, 1, 0, 0);
        cyc(); set_ldu(5'd7, 1'b1, 5'd7); ext_hold_i = 1'b1;
        expv("hold_ldu", 5'b00000, 5'b00000, 0, 32'h0, 0, 0, 0, 0);

        // MC lat=3; start in MCWAIT is ignored
        cyc(); ex_mc_start_i = 1'b1; ex_mc_lat_i = 6'd3;
        expv("mc3_c0", 5'b11000, 5'b01000, 0, 32'h0, 0, 0, 1, 0);
        cyc();
        expv("mc3_c1", 5'b11000, 5'b01000, 0, 32'h0, 1, 0, 1, 0);
        cyc(); ex_mc_start_i = 1'b1; ex_mc_lat_i = 6'd7;
        expv("mc3_c2", 5'b11000, 5'b01000, 0, 32'h0, 1, 0, 1, 0);
        cyc();
        expv("mc3_rel", 5'b11111, 5'b00000, 0, 32'h0, 1, 0, 0, 0);
        cyc();
        expv("mc3_run", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);
        cyc(); ex_mc_start_i = 1'b1; ex_mc_lat_i = 6'd0;
        expv("mc_lat0", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);

        // Jump beats a coincident load-use
        cyc(); set_ldu(5'd5, 1'b1, 5'd5); ex_jump_i = 1'b1; ex_jump_addr_i = 32'h80;
        expv("jump_ldu", 5'b11111, 5'b00110, 1, 32'h80, 0, 0, 0, 1);
        cyc(); ex_jump_addr_i = 32'h1234;
        expv("addr_passthru", 5'b11111, 5'b00000, 0, 32'h1234, 0, 0, 0, 0);

        // MC lat=4 with 2 hold cycles mid-wait; jump during stall is ignored
        cyc(); ex_mc_start_i = 1'b1; ex_mc_lat_i = 6'd4;
        expv("mc4_c0", 5'b11000, 5'b01000, 0, 32'h0, 0, 0, 1, 0);
        cyc();
        expv("mc4_c1", 5'b11000, 5'b01000, 0, 32'h0, 1, 0, 1, 0);
        cyc(); ext_hold_i = 1'b1;
        expv("mc4_hold1", 5'b00000, 5'b00000, 0, 32'h0, 1, 0, 0, 0);
        cyc(); ext_hold_i = 1'b1;
        expv("mc4_hold2", 5'b00000, 5'b00000, 0, 32'h0, 1, 0, 0, 0);
        cyc(); ex_jump_i = 1'b1; ex_jump_addr_i = 32'h40;
        expv("mc4_c4_jump", 5'b11000, 5'b01000, 0, 32'h40, 1, 0, 1, 0);
        cyc();
        expv("mc4_c5", 5'b11000, 5'b01000, 0, 32'h0, 1, 0, 1, 0);
        cyc();
        expv("mc4_rel", 5'b11111, 5'b00000, 0, 32'h0, 1, 0, 0, 0);
        cyc();
        expv("mc4_run", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);

        // Reset while in MCWAIT with cnt=2, then a lat=1 op proves the timer was cleared
        cyc(); ex_mc_start_i = 1'b1; ex_mc_lat_i = 6'd4;
        expv("rst_mc_c0", 5'b11000, 5'b01000, 0, 32'h0, 0, 0, 1, 0);
        cyc();
        expv("rst_mc_c1", 5'b11000, 5'b01000, 0, 32'h0, 1, 0, 1, 0);
        cyc(); rstn = 1'b0;
        exp_ldu = 0; exp_mc = 0; exp_fl = 0;
        expv("rst_in_wait", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);
        cyc();
        expv("rst_after", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);
        cyc(); ex_mc_start_i = 1'b1; ex_mc_lat_i = 6'd1;
        expv("mc1_c0", 5'b11000, 5'b01000, 0, 32'h0, 0, 0, 1, 0);
        cyc();
        expv("mc1_rel", 5'b11111, 5'b00000, 0, 32'h0, 1, 0, 0, 0);
        cyc();
        expv("mc1_run", 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
